// File: rtl/seq_divider_8x4_if.sv
// Operand and result valid/ready bundle for seq_divider_8x4.
// io_divzero is present only when DIV_ZERO_CHECK_EN is defined.
interface seq_divider_8x4_if #(
  parameter int N_W = 8,
  parameter int D_W = 4
);
  logic           io_in_valid;
  logic           io_in_ready;
  logic [N_W-1:0] io_n;
  logic [D_W-1:0] io_d;
  logic           io_out_valid;
  logic           io_out_ready;
  logic [N_W-1:0] io_q;
  logic [D_W-1:0] io_r;
`ifdef DIV_ZERO_CHECK_EN
  logic           io_divzero;

  modport master (
    output io_in_valid,
    output io_n,
    output io_d,
    output io_out_ready,
    input  io_in_ready,
    input  io_out_valid,
    input  io_q,
    input  io_r,
    input  io_divzero
  );

  modport slave (
    input  io_in_valid,
    input  io_n,
    input  io_d,
    input  io_out_ready,
    output io_in_ready,
    output io_out_valid,
    output io_q,
    output io_r,
    output io_divzero
  );
`else
  modport master (
    output io_in_valid,
    output io_n,
    output io_d,
    output io_out_ready,
    input  io_in_ready,
    input  io_out_valid,
    input  io_q,
    input  io_r
  );

  modport slave (
    input  io_in_valid,
    input  io_n,
    input  io_d,
    input  io_out_ready,
    output io_in_ready,
    output io_out_valid,
    output io_q,
    output io_r
  );
`endif
endinterface

// File: rtl/seq_divider_8x4.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle.
// Define DIV_ZERO_CHECK_EN to short-circuit zero divisors and flag io_divzero.
module seq_divider_8x4 #(
  parameter int N_W = 8,
  parameter int D_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  seq_divider_8x4_if.slave  bus
);

  localparam int CW = (N_W > 1) ? $clog2(N_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [N_W-1:0] qreg;
  logic [D_W-1:0] rem;
  logic [D_W-1:0] dreg;
  logic [CW-1:0]  count;

  logic [D_W:0]   trial;
  logic           ge;
  logic [D_W-1:0] diff;
  logic           zero_d;

  logic           in_ready;
  logic           out_valid;
  logic [N_W-1:0] q_o;
  logic [D_W-1:0] r_o;

`ifdef DIV_ZERO_CHECK_EN
  logic           dz;
  logic           dz_o;

  assign zero_d = ~|bus.io_d;
`else
  assign zero_d = 1'b0;
`endif

  // Restored remainder is always < d, so only D_W bits are stored;
  // the shifted trial value keeps the extra bit for the compare.
  always_comb begin
    trial = {rem, qreg[N_W-1]};
    ge    = trial >= {1'b0, dreg};
    diff  = trial[D_W-1:0] - dreg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.io_in_valid) begin
          state_nxt = zero_d ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (count == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.io_out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    q_o       = '0;
    r_o       = '0;
`ifdef DIV_ZERO_CHECK_EN
    dz_o      = 1'b0;
`endif
    unique case (state)
      IDLE: in_ready = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        q_o       = qreg;
        r_o       = rem;
`ifdef DIV_ZERO_CHECK_EN
        dz_o      = dz;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      qreg  <= '0;
      rem   <= '0;
      dreg  <= '0;
      count <= '0;
`ifdef DIV_ZERO_CHECK_EN
      dz    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.io_in_valid) begin
            dreg <= bus.io_d;
`ifdef DIV_ZERO_CHECK_EN
            if (zero_d) begin
              qreg  <= '1;
              rem   <= bus.io_n[D_W-1:0];
              count <= '0;
              dz    <= 1'b1;
            end else begin
              qreg  <= bus.io_n;
              rem   <= '0;
              count <= CW'(N_W - 1);
            end
`else
            qreg  <= bus.io_n;
            rem   <= '0;
            count <= CW'(N_W - 1);
`endif
          end
        end
        BUSY: begin
          rem  <= ge ? diff : trial[D_W-1:0];
          qreg <= {qreg[N_W-2:0], ge};
          if (count != '0) begin
            count <= count - CW'(1);
          end
        end
        DONE: begin
`ifdef DIV_ZERO_CHECK_EN
          if (bus.io_out_ready) begin
            dz <= 1'b0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.io_in_ready  = in_ready;
  assign bus.io_out_valid = out_valid;
  assign bus.io_q         = q_o;
  assign bus.io_r         = r_o;
`ifdef DIV_ZERO_CHECK_EN
  assign bus.io_divzero   = dz_o;
`endif

endmodule

// File: tb/tb_seq_divider_8x4.sv
// Directed and randomized checks of seq_divider_8x4 against an arithmetic model.
// Expectations follow DIV_ZERO_CHECK_EN when it is defined for the build.
module tb_seq_divider_8x4;

  localparam int N_W = 8;
  localparam int D_W = 4;
`ifdef DIV_ZERO_CHECK_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seq_divider_8x4_if #(.N_W(N_W), .D_W(D_W)) bus ();

  seq_divider_8x4 #(.N_W(N_W), .D_W(D_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int n, input int d,
                                output int q, output int r,
                                output int lat);
    if (d == 0) begin
      q   = (1 << N_W) - 1;
      r   = n % (1 << D_W);
      lat = DZ ? 1 : N_W + 1;
    end else begin
      q   = n / d;
      r   = n % d;
      lat = N_W + 1;
    end
  endfunction

  task automatic op(input int n, input int d, input int hold,
                    input string tag);
    int             eq, er, el, lat, waitc;
    bit             early_ready, stable;
    logic [N_W-1:0] q0;
    logic [D_W-1:0] r0;
    model(n, d, eq, er, el);
    waitc = 0;
    while (!bus.io_in_ready && waitc < 20) begin
      @(negedge clock);
      waitc++;
    end
    chk({tag, "_in_ready"}, 32'(bus.io_in_ready), 1);
    bus.io_in_valid  = 1'b1;
    bus.io_n         = N_W'(n);
    bus.io_d         = D_W'(d);
    bus.io_out_ready = (hold == 0);
    @(negedge clock);
    bus.io_in_valid = 1'b0;
    bus.io_n        = N_W'($urandom);
    bus.io_d        = D_W'($urandom);
    lat         = 1;
    early_ready = 1'b0;
    while (!bus.io_out_valid && lat < 40) begin
      if (bus.io_in_ready) early_ready = 1'b1;
      @(negedge clock);
      lat++;
    end
    chk({tag, "_latency"}, lat, el);
    chk({tag, "_ready_busy"}, 32'(early_ready), 0);
    chk({tag, "_ready_done"}, 32'(bus.io_in_ready), 0);
    chk({tag, "_q"}, 32'(bus.io_q), eq);
    chk({tag, "_r"}, 32'(bus.io_r), er);
    if (d != 0) begin
      chk({tag, "_invariant"},
          32'((int'(bus.io_q) * d + int'(bus.io_r) == n) &&
              (int'(bus.io_r) < d)), 1);
    end
`ifdef DIV_ZERO_CHECK_EN
    chk({tag, "_divzero"}, 32'(bus.io_divzero), 32'(d == 0));
`endif
    q0     = bus.io_q;
    r0     = bus.io_r;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (bus.io_in_ready || !bus.io_out_valid ||
          bus.io_q !== q0 || bus.io_r !== r0) stable = 1'b0;
    end
    if (hold > 0) begin
      chk({tag, "_held_stable"}, 32'(stable), 1);
      bus.io_out_ready = 1'b1;
    end
    @(negedge clock);
    bus.io_out_ready = 1'b0;
    chk({tag, "_out_valid_clr"}, 32'(bus.io_out_valid), 0);
    chk({tag, "_ready_back"}, 32'(bus.io_in_ready), 1);
`ifdef DIV_ZERO_CHECK_EN
    chk({tag, "_divzero_clr"}, 32'(bus.io_divzero), 0);
`endif
  endtask

  initial begin
    int  idx[$];
    int  j, tmp, waitc;
    bit  spurious;
    bus.io_in_valid  = 1'b0;
    bus.io_n         = '0;
    bus.io_d         = '0;
    bus.io_out_ready = 1'b0;

    // Reset values
    @(negedge clock);
    chk("rst_in_ready", 32'(bus.io_in_ready), 1);
    chk("rst_out_valid", 32'(bus.io_out_valid), 0);
    chk("rst_q", 32'(bus.io_q), 0);
    chk("rst_r", 32'(bus.io_r), 0);
`ifdef DIV_ZERO_CHECK_EN
    chk("rst_divzero", 32'(bus.io_divzero), 0);
`endif
    reset = 1'b0;
    @(negedge clock);

    // T1..T4 directed
    op(200, 7, 0, "t1");
    op(255, 15, 0, "t2a");
    op(5, 9, 0, "t2b");
    op(100, 3, 20, "t3");
    op(8'hA6, 0, 1, "t4");
    op(0, 1, 0, "n_zero");
    op(15, 15, 0, "n_eq_d");
    op(255, 1, 2, "d_one");

    // T5: reset in the middle of BUSY
    waitc = 0;
    while (!bus.io_in_ready && waitc < 20) begin
      @(negedge clock);
      waitc++;
    end
    bus.io_in_valid  = 1'b1;
    bus.io_n         = 8'd77;
    bus.io_d         = 4'd5;
    bus.io_out_ready = 1'b1;
    @(negedge clock);
    bus.io_in_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("t5_rst_out_valid", 32'(bus.io_out_valid), 0);
    chk("t5_rst_in_ready", 32'(bus.io_in_ready), 1);
    @(negedge clock);
    reset    = 1'b0;
    spurious = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (bus.io_out_valid || !bus.io_in_ready) spurious = 1'b1;
    end
    chk("t5_no_result", 32'(spurious), 0);
    bus.io_out_ready = 1'b0;
    op(77, 5, 0, "t5b");

    // T6: all nonzero-divisor pairs in random order
    for (int n = 0; n < 256; n++) begin
      for (int d = 1; d < 16; d++) idx.push_back(n * 16 + d);
    end
    for (int i = idx.size() - 1; i > 0; i--) begin
      j      = $urandom_range(i, 0);
      tmp    = idx[i];
      idx[i] = idx[j];
      idx[j] = tmp;
    end
    foreach (idx[k]) begin
      op(idx[k] / 16, idx[k] % 16, $urandom_range(2, 0), "t6");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
